spi_master_sclkgen: RTL and testbench

Parametrised SPI master serial-clock and bit-timing generator for the APB SPI master. It generates SCLK from sys_clk with a programmable divider and supports all four CPOL/CPHA modes. Each transfer runs a programmable bit count under a start/busy/done handshake. It also issues one-cycle launch and sample strobes that the shifter uses to drive MOSI and capture MISO.

---
 rtl/spi_master_sclkgen.sv | 124 ++++++++++++
 tb/tb_spi_master_sclkgen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_sclkgen.sv
// rtl/spi_master_sclkgen.sv - SPI master SCLK and bit-timing generator
// Produces SCLK for all CPOL/CPHA modes plus one-cycle launch/sample strobes for the shifter.
module spi_master_sclkgen #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 6
) (
  input  logic             sys_clk,
  input  logic             rst_b,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_cpol,
  input  logic             cfg_cpha,
  input  logic [CNT_W-1:0] cfg_nbits,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             launch_stb,
  output logic             sample_stb,
  output logic [CNT_W-1:0] bit_idx
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;

  logic [1:0]       state;
  logic [DIV_W-1:0] hc;
  logic [CNT_W:0]   ec;
  logic [DIV_W-1:0] div_l;
  logic             cpol_l;
  logic             cpha_l;
  logic [CNT_W-1:0] nbits_l;

  logic             half_done;
  logic             leading;
  logic             last_edge;
  logic             sample_now;

  // ec counts completed edges; the final edge (2N) is seen when ec == 2N-1.
  assign half_done  = (hc == div_l);
  assign leading    = ~ec[0];
  assign last_edge  = (ec == {nbits_l, 1'b1});
  assign sample_now = cpha_l ? ~leading : leading;

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      hc         <= '0;
      ec         <= '0;
      div_l      <= '0;
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
      nbits_l    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sclk       <= 1'b0;
      launch_stb <= 1'b0;
      sample_stb <= 1'b0;
      bit_idx    <= '0;
    end else if (abort) begin
      state      <= IDLE;
      hc         <= '0;
      ec         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sclk       <= (state == IDLE) ? cfg_cpol : cpol_l;
      launch_stb <= 1'b0;
      sample_stb <= 1'b0;
      bit_idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          if (half_done) begin
            hc   <= '0;
            sclk <= ~sclk;
            ec   <= ec + 1'b1;
            // Leading edges sample in mode 0 and launch in mode 1; trailing edges do the opposite.
            sample_stb <= sample_now;
            launch_stb <= cpha_l ? leading : (~leading & ~last_edge);
            if (sample_now) bit_idx <= bit_idx + 1'b1;
            if (last_edge) state <= TAIL;
          end else begin
            hc         <= hc + 1'b1;
            launch_stb <= 1'b0;
            sample_stb <= 1'b0;
          end
        end
        TAIL: begin
          launch_stb <= 1'b0;
          sample_stb <= 1'b0;
          if (half_done) begin
            hc    <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            hc <= hc + 1'b1;
          end
        end
        default: begin
          sclk       <= cfg_cpol;
          sample_stb <= 1'b0;
          launch_stb <= 1'b0;
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            hc         <= '0;
            ec         <= '0;
            bit_idx    <= '0;
            div_l      <= cfg_div;
            cpol_l     <= cfg_cpol;
            cpha_l     <= cfg_cpha;
            nbits_l    <= cfg_nbits;
            // Mode 0 must present the first MOSI bit before the first (sampling) edge.
            launch_stb <= ~cfg_cpha;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_sclkgen.sv
// tb/tb_spi_master_sclkgen.sv - self-checking bench for spi_master_sclkgen
// Expected waveforms come from a cycle-index arithmetic model of the bit timing.
module tb_spi_master_sclkgen;

  localparam int DIV_W = 8;
  localparam int CNT_W = 4;

  logic             sys_clk = 1'b0;
  logic             rst_b;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_cpol;
  logic             cfg_cpha;
  logic [CNT_W-1:0] cfg_nbits;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             sclk;
  logic             launch_stb;
  logic             sample_stb;
  logic [CNT_W-1:0] bit_idx;

  int checks = 0;
  int errors = 0;

  spi_master_sclkgen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .sys_clk    (sys_clk),
    .rst_b      (rst_b),
    .cfg_div    (cfg_div),
    .cfg_cpol   (cfg_cpol),
    .cfg_cpha   (cfg_cpha),
    .cfg_nbits  (cfg_nbits),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .sclk       (sclk),
    .launch_stb (launch_stb),
    .sample_stb (sample_stb),
    .bit_idx    (bit_idx)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Expected {busy, done, sclk, launch, sample} in cycle t after the accepting edge (t=1 is the first RUN cycle).
  function automatic logic [4:0] exp_vec(int t, int d, int cp, int ph, int n);
    int p, tot, e, k;
    logic s, la, sa;
    p   = d + 1;
    tot = (2 * n + 1) * p;
    if (t > tot) return {1'b0, 1'b1, cp[0], 1'b0, 1'b0};
    e  = (t - 1) / p;
    s  = cp[0] ^ e[0];
    la = 1'b0;
    sa = 1'b0;
    if (t == 1 && ph == 0) la = 1'b1;
    if (t > 1 && ((t - 1) % p) == 0) begin
      k = e;
      if (ph == 0) begin
        if (k % 2 == 1) sa = 1'b1;
        else if (k != 2 * n) la = 1'b1;
      end else begin
        if (k % 2 == 1) la = 1'b1;
        else sa = 1'b1;
      end
    end
    return {1'b1, 1'b0, s, la, sa};
  endfunction

  // Runs one transfer and compares every cycle against the model.
  // chained: start is already high and the accepting edge is the next one.
  // hold_next: keep start high so another transfer is accepted in the done cycle.
  // abort_at: edge number after which abort is pulsed (0 = none).
  task automatic run_xfer(input int d, input int cp, input int ph, input int nb, input bit scramble,
                          input bit chained, input bit hold_next, input int abort_at, input string name);
    int n, tot;
    logic [4:0] obs, exp;
    n   = nb + 1;
    tot = (2 * n + 1) * (d + 1);
    cfg_div   = d[DIV_W-1:0];
    cfg_cpol  = cp[0];
    cfg_cpha  = ph[0];
    cfg_nbits = nb[CNT_W-1:0];
    if (!chained) begin
      start = 1'b0;
      tick();
      tick();
      checks++;
      if (sclk !== cp[0]) begin
        errors++;
        $display("FAIL %s idle_sclk got %0b want %0b", name, sclk, cp[0]);
      end
      start = 1'b1;
    end
    tick();
    if (!hold_next) start = 1'b0;
    for (int t = 1; t <= tot + 1; t++) begin
      obs = {busy, done, sclk, launch_stb, sample_stb};
      exp = exp_vec(t, d, cp, ph, n);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s t=%0d {busy,done,sclk,launch,sample} got %b want %b", name, t, obs, exp);
      end
      if (t == tot + 1) begin
        checks++;
        if (bit_idx !== n[CNT_W-1:0]) begin
          errors++;
          $display("FAIL %s bit_idx got %0d want %0d", name, bit_idx, n[CNT_W-1:0]);
        end
      end else begin
        if (abort_at > 0 && t == abort_at * (d + 1) + 1) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          for (int c = 0; c < 2 * (d + 1) + 3; c++) begin
            obs = {busy, done, sclk, launch_stb, sample_stb};
            exp = {1'b0, 1'b0, cp[0], 1'b0, 1'b0};
            checks++;
            if (obs !== exp || bit_idx !== '0) begin
              errors++;
              $display("FAIL %s post_abort c=%0d got %b idx %0d want %b idx 0", name, c, obs, bit_idx, exp);
            end
            tick();
          end
          return;
        end
        if (scramble && t == 2) begin
          cfg_div   = DIV_W'($urandom);
          cfg_cpol  = ~cfg_cpol;
          cfg_cpha  = ~cfg_cpha;
          cfg_nbits = CNT_W'($urandom);
          start     = 1'b1;
        end
        if (scramble && t == 3) start = 1'b0;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_div = '0; cfg_cpol = 1'b1; cfg_cpha = 1'b0; cfg_nbits = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if ({busy, done, sclk, launch_stb, sample_stb, bit_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {busy, done, sclk, launch_stb, sample_stb, bit_idx});
    end
    @(negedge sys_clk);
    rst_b = 1'b1;
    tick();
    checks++;
    if (sclk !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release sclk %0b busy %0b want 1 0", sclk, busy);
    end
  endtask

  task automatic test_modes();
    run_xfer(1, 0, 0, 7, 1'b0, 1'b0, 1'b0, 0, "mode0_div1_n8");
    run_xfer(0, 1, 1, 3, 1'b0, 1'b0, 1'b0, 0, "mode3_div0_n4");
    run_xfer(2, 1, 0, 2, 1'b0, 1'b0, 1'b0, 0, "mode2_div2_n3");
    run_xfer(1, 0, 1, 4, 1'b0, 1'b0, 1'b0, 0, "mode1_div1_n5");
  endtask

  task automatic test_limits();
    run_xfer((1 << DIV_W) - 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, "max_div_n1");
    run_xfer(0, 0, 1, (1 << CNT_W) - 1, 1'b0, 1'b0, 1'b0, 0, "max_nbits");
  endtask

  task automatic test_config_change();
    run_xfer(1, 0, 0, 5, 1'b1, 1'b0, 1'b0, 0, "cfg_change");
    tick();
    checks++;
    if (sclk !== cfg_cpol || busy !== 1'b0) begin
      errors++;
      $display("FAIL cfg_change_after sclk %0b busy %0b want %0b 0", sclk, busy, cfg_cpol);
    end
  endtask

  task automatic test_back_to_back();
    run_xfer(0, 0, 1, 2, 1'b0, 1'b0, 1'b1, 0, "b2b_first");
    run_xfer(1, 1, 0, 1, 1'b0, 1'b1, 1'b0, 0, "b2b_second");
  endtask

  task automatic test_abort();
    run_xfer(1, 1, 0, 7, 1'b0, 1'b0, 1'b0, 5, "abort_edge5");
    run_xfer(1, 1, 0, 7, 1'b0, 1'b0, 1'b0, 0, "after_abort");
    start = 1'b1;
    abort = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || launch_stb !== 1'b0) begin
      errors++;
      $display("FAIL abort_with_start busy %0b launch %0b want 0 0", busy, launch_stb);
    end
    start = 1'b0;
    abort = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    cfg_div = 8'd2; cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_nbits = 4'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({busy, done, sclk, launch_stb, sample_stb, bit_idx} !== '0) begin
      errors++;
      $display("FAIL async_reset got %b want 0", {busy, done, sclk, launch_stb, sample_stb, bit_idx});
    end
    @(negedge sys_clk);
    rst_b = 1'b1;
    tick();
    checks++;
    if (sclk !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_release sclk %0b busy %0b want 1 0", sclk, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_xfer(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, (1 << CNT_W) - 1)), 1'($urandom_range(0, 1)),
               1'b0, 1'b0, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_limits();
    test_config_change();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
